// File: rtl/tick_divider_multi_if.sv
// tick_divider_multi_if: enable/start inputs, config write port and tick outputs of the divider.
interface tick_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] en_i;
  logic [NUM_CH-1:0] start_i;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] sq_o;
  logic [NUM_CH-1:0] done_o;
  modport master (
    output en_i, start_i, cfg_we, cfg_ch, cfg_div, cfg_mode,
    input  cfg_err, tick_o, sq_o, done_o
  );
  modport slave (
    input  en_i, start_i, cfg_we, cfg_ch, cfg_div, cfg_mode,
    output cfg_err, tick_o, sq_o, done_o
  );
endinterface

// File: rtl/tick_divider_multi.sv
// tick_divider_multi: per-channel programmable tick/square-wave generator with periodic and one-shot modes.
module tick_divider_multi #(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 32,
  parameter int unsigned DEF_DIV = 100000000
) (
  input logic clk,
  input logic rst,
  tick_divider_multi_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d, armed_q, armed_d, sq_q, sq_d, done_q, done_d, tick_q, tick_d;
  logic              cfg_ok, term, err_q;
  // Priority per channel: config write, then start, then terminal count.
  always_comb begin
    cfg_ok = bus.cfg_div >= CNT_W'(2) && {1'b0, bus.cfg_ch} < (CH_W+1)'(NUM_CH);
    term = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      div_d[c] = div_q[c];
      cnt_d[c] = cnt_q[c];
      mode_d[c] = mode_q[c];
      armed_d[c] = armed_q[c];
      sq_d[c] = sq_q[c];
      done_d[c] = done_q[c];
      tick_d[c] = 1'b0;
      term = cnt_q[c] == div_q[c] - CNT_W'(1);
      if (bus.cfg_we && cfg_ok && bus.cfg_ch == CH_W'(c)) begin
        div_d[c] = bus.cfg_div;
        mode_d[c] = bus.cfg_mode;
        cnt_d[c] = '0;
        armed_d[c] = 1'b0;
        sq_d[c] = 1'b0;
        done_d[c] = 1'b0;
      end else if (!mode_q[c]) begin
        if (bus.en_i[c]) begin
          cnt_d[c] = term ? '0 : cnt_q[c] + CNT_W'(1);
          tick_d[c] = term;
          sq_d[c] = sq_q[c] ^ term;
        end
      end else if (bus.start_i[c]) begin
        armed_d[c] = 1'b1;
        cnt_d[c] = '0;
        done_d[c] = 1'b0;
      end else if (armed_q[c] && bus.en_i[c]) begin
        cnt_d[c] = term ? '0 : cnt_q[c] + CNT_W'(1);
        tick_d[c] = term;
        armed_d[c] = !term;
        done_d[c] = term;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        div_q[c] <= CNT_W'(DEF_DIV);
        cnt_q[c] <= '0;
      end
      mode_q <= '0;
      armed_q <= '0;
      sq_q <= '0;
      done_q <= '0;
      tick_q <= '0;
      err_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      armed_q <= armed_d;
      sq_q <= sq_d;
      done_q <= done_d;
      tick_q <= tick_d;
      err_q <= bus.cfg_we && !cfg_ok;
    end
  end
  assign bus.tick_o = tick_q;
  assign bus.sq_o = sq_q;
  assign bus.done_o = done_q;
  assign bus.cfg_err = err_q;
endmodule
